// File: rtl/ddr_pattern_gen.sv
// DDR3 write-traffic generator: four data patterns, FIFO full/empty hysteresis, optional bounded run.
// Define PATGEN_CHECK_EN to add a read-back checker driven by a shadow pattern generator.
module ddr_pattern_gen #(
  parameter int unsigned DATA_W      = 256,
  parameter int unsigned TOTAL_BEATS = 0,
  parameter int unsigned CNT_W       = 32
) (
  input  logic              ui_clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [31:0]       seed,
  input  logic              empty,
  input  logic              full,
  input  logic              data_req,
`ifdef PATGEN_CHECK_EN
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic [15:0]       err_cnt,
  output logic              err_flag,
`endif
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  beat_cnt
);

  localparam int unsigned      NL       = DATA_W / 32;
  localparam logic [31:0]      LfsrMask = 32'h8020_0003;
  localparam bit               Bounded  = (TOTAL_BEATS != 0);
  localparam logic [CNT_W-1:0] TotalC   = CNT_W'(TOTAL_BEATS);

  typedef enum logic [1:0] {StIdle, StFill, StHold, StDone} state_e;

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? LfsrMask : 32'h0);
  endfunction

  function automatic logic [31:0] lfsr_init(input logic [31:0] s);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

  function automatic logic [DATA_W-1:0] gen_beat(input logic [1:0]  m,
                                                 input logic [31:0] s,
                                                 input logic [31:0] k,
                                                 input logic [31:0] l);
    logic [DATA_W-1:0] b;
    logic [31:0]       lane;
    logic [31:0]       idx;
    logic [4:0]        sh;
    b = '0;
    for (int i = 0; i < NL; i++) begin
      idx  = 32'(i);
      sh   = s[4:0] + k[4:0] + idx[4:0];
      case (m)
        2'd0:    lane = s + k + idx;
        2'd1:    lane = 32'h1 << sh;
        2'd2:    lane = l ^ idx;
        default: lane = (k[0] ^ idx[0]) ? 32'h5555_5555 : 32'hAAAA_AAAA;
      endcase
      b[32*i +: 32] = lane;
    end
    return b;
  endfunction

  state_e              state_q, state_d;
  logic                wr_en_q, wr_en_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [1:0]          mode_q, mode_d;
  logic [31:0]         seed_q, seed_d;
  logic [31:0]         k_q, k_d;
  logic [31:0]         lfsr_q, lfsr_d;
  logic                start_ok;
  logic                adv;

  assign start_ok = start && !busy_q;
  assign adv      = data_req && busy_q;

  always_comb begin
    state_d    = state_q;
    wr_data_d  = wr_data_q;
    beat_cnt_d = beat_cnt_q;
    mode_d     = mode_q;
    seed_d     = seed_q;
    k_d        = k_q;
    lfsr_d     = lfsr_q;

    if (start_ok) begin
      state_d    = StFill;
      beat_cnt_d = '0;
      mode_d     = mode;
      seed_d     = seed;
      k_d        = 32'h0;
      lfsr_d     = lfsr_init(seed);
      wr_data_d  = gen_beat(mode, seed, 32'h0, lfsr_init(seed));
    end else begin
      unique case (state_q)
        StFill:  if (full) state_d = StHold;
        StHold:  if (empty && !full) state_d = StFill;
        default: ;
      endcase
      if (adv) begin
        k_d        = k_q + 32'd1;
        lfsr_d     = lfsr_step(lfsr_q);
        beat_cnt_d = beat_cnt_q + CNT_W'(1);
        wr_data_d  = gen_beat(mode_q, seed_q, k_d, lfsr_d);
        if (Bounded && (beat_cnt_d == TotalC)) state_d = StDone;
      end
    end

    // Outputs are registered copies of the next state so they track state_q exactly.
    wr_en_d = (state_d == StFill);
    busy_d  = (state_d == StFill) || (state_d == StHold);
    done_d  = (state_d == StDone);
  end

  always_ff @(posedge ui_clk) begin
    if (rst) begin
      state_q    <= StIdle;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      beat_cnt_q <= '0;
      mode_q     <= 2'd0;
      seed_q     <= 32'h0;
      k_q        <= 32'h0;
      lfsr_q     <= 32'h1;
    end else begin
      state_q    <= state_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      beat_cnt_q <= beat_cnt_d;
      mode_q     <= mode_d;
      seed_q     <= seed_d;
      k_q        <= k_d;
      lfsr_q     <= lfsr_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign beat_cnt = beat_cnt_q;

`ifdef PATGEN_CHECK_EN
  logic [31:0] chk_k_q, chk_k_d;
  logic [31:0] chk_lfsr_q, chk_lfsr_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic        err_flag_q, err_flag_d;
  logic        mismatch;

  assign mismatch = rd_data != gen_beat(mode_q, seed_q, chk_k_q, chk_lfsr_q);

  always_comb begin
    chk_k_d    = chk_k_q;
    chk_lfsr_d = chk_lfsr_q;
    err_cnt_d  = err_cnt_q;
    err_flag_d = err_flag_q;
    if (start_ok) begin
      chk_k_d    = 32'h0;
      chk_lfsr_d = lfsr_init(seed);
      err_cnt_d  = 16'h0;
      err_flag_d = 1'b0;
    end else if (rd_valid) begin
      chk_k_d    = chk_k_q + 32'd1;
      chk_lfsr_d = lfsr_step(chk_lfsr_q);
      if (mismatch) begin
        err_flag_d = 1'b1;
        if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge ui_clk) begin
    if (rst) begin
      chk_k_q    <= 32'h0;
      chk_lfsr_q <= 32'h1;
      err_cnt_q  <= 16'h0;
      err_flag_q <= 1'b0;
    end else begin
      chk_k_q    <= chk_k_d;
      chk_lfsr_q <= chk_lfsr_d;
      err_cnt_q  <= err_cnt_d;
      err_flag_q <= err_flag_d;
    end
  end

  assign err_cnt  = err_cnt_q;
  assign err_flag = err_flag_q;
`endif

endmodule

// File: doc/ddr_pattern_gen.md
Name: ddr_pattern_gen

Overview:
- Parametrised DDR3 write-traffic generator for memory test paths. Drives a write FIFO feeding the DDR3 user-interface write path.
- Fill control uses full/empty hysteresis on the FIFO. The pattern advances on each data_req beat.
- Supports four selectable data patterns, an optional bounded beat count with a done indication, and a start/restart handshake.

Parameters:
- DATA_W, 256, write data width; must be a multiple of 32 (NL = DATA_W/32 lanes).
- TOTAL_BEATS, 0, beats per run. 0 means run forever.
- CNT_W, 32, width of beat_cnt.

Ports:
- ui_clk  input  1  sole clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a run. Honoured only when busy=0.
- mode  input  2  pattern select, sampled on an accepted start.
- seed  input  32  pattern seed, sampled on an accepted start.
- empty  input  1  FIFO empty.
- full  input  1  FIFO full.
- data_req  input  1  consumer accepted the current wr_data beat.
- wr_en  output  1  FIFO write enable.
- wr_data  output  DATA_W  current pattern beat.
- busy  output  1  run in progress.
- done  output  1  bounded run finished. Sticky until the next start or rst.
- beat_cnt  output  CNT_W  data_req beats accepted in this run.

Behaviour:
- Reset values: wr_en=0, wr_data=0, busy=0, done=0, beat_cnt=0, state=IDLE.
- States:
  - IDLE: on start, go to FILL. Set busy=1, done=0, beat_cnt=0, k=0, latch mode and seed. Load beat 0 into wr_data; it is visible the cycle after start.
  - FILL: wr_en=1 (registered). If full, go to HOLD; wr_en=0 the next cycle.
  - HOLD: wr_en=0. If empty and not full, go to FILL.
  - DONE: wr_en=0, busy=0, done=1. A start here behaves exactly as start in IDLE.
- If full and empty are both high in the same cycle, full wins: wr_en=0.
- start while busy=1 is ignored.
- data_req:
  - Counted only while busy=1. Ignored in IDLE and DONE; wr_data and beat_cnt are held.
  - Each counted data_req increments k and beat_cnt, and registers beat k+1 into wr_data. Latency is one cycle.
  - beat_cnt wraps modulo 2^CNT_W.
- Bounded run (TOTAL_BEATS>0): on the data_req that makes beat_cnt==TOTAL_BEATS, the next state is DONE. wr_en drops the next cycle. wr_data holds the last advanced beat.
- Pattern for beat k, lane i (bits 32i+31:32i), all arithmetic mod 2^32:
  - mode 0, increment: seed + k + i.
  - mode 1, walking one: 1 << ((seed[4:0] + k + i) mod 32).
  - mode 2, PRBS: L_k XOR i.
    - L_0 = seed, or 32'h1 if seed==0.
    - L_{k+1} is a one-step Galois LFSR of L_k with polynomial x^32+x^22+x^2+x+1 (tap mask 32'h80200003). Shift right; XOR the mask when the lsb is 1.
  - mode 3, checkerboard: lane = 32'hAAAAAAAA when (k+i) is even, 32'h55555555 when odd.
- rst mid-run: all outputs return to their reset values the cycle after rst is sampled. A start in the same cycle as rst is ignored.

Optional Feature:
- Macro PATGEN_CHECK_EN.
- When defined, the block adds these ports:
  - rd_valid  input  1
  - rd_data  input  DATA_W
  - err_cnt  output  16
  - err_flag  output  1
- A shadow generator is reloaded with the latched mode and seed on each accepted start. It produces the expected beat j for the j-th rd_valid beat.
- On a mismatch, err_cnt increments, saturating at 16'hFFFF, and err_flag is set (sticky). Both update the cycle after rd_valid.
- err_cnt and err_flag clear on rst or an accepted start.
- When not defined, the ports and logic are absent and the write behaviour is identical.

Test Plan:
- Increment, unbounded:
  - Stimulus: rst, then start with mode=0, seed=32'h10. Pulse data_req 3 times.
  - Required: wr_data lane0 = 32'h10, 11, 12, 13 in sequence; lane7 = 32'h17 initially; beat_cnt=3.
- Hysteresis:
  - Stimulus: in FILL, raise full for 1 cycle, then empty=1.
  - Required: wr_en drops 1 cycle after full and re-asserts 1 cycle after empty. With full=1 and empty=1 simultaneously, wr_en stays 0.
- Bounded run:
  - Stimulus: TOTAL_BEATS=4, stream data_req continuously.
  - Required: after the 4th data_req, busy=0 and done=1; a 5th data_req leaves beat_cnt=4 and wr_data unchanged.
  - Then start again: done clears and beat_cnt=0.
- Pattern modes:
  - mode 2 with seed=0: lane0 = 32'h1 at beat 0 and 32'h80200003 at beat 1.
  - mode 1 with seed=31: lane0 = 32'h80000000 at beat 0 and 32'h1 at beat 1.
  - mode 3: lane0 = 32'hAAAAAAAA, lane1 = 32'h55555555 at beat 0.
- Reset and start rules:
  - rst asserted mid-FILL: all outputs are 0 the next cycle.
  - start pulsed while busy: mode and seed are unchanged.
- Checker (PATGEN_CHECK_EN):
  - Loop wr_data back to rd_data over 8 beats: err_cnt=0.
  - Flip one bit in beat 5: err_cnt=1 and err_flag=1.
